pulse_stretcher: RTL and testbench
==================================

// Module: pulse_stretcher
// PURPOSE
//  Inverse of the button edge-detector FSM. Takes single-cycle request pulses and replays
//  each one as a button-like level waveform: OUT_POLARITY for HIGH_CYCLES, then inactive
//  for LOW_CYCLES. Used to drive LEDs/strobes from pulse events and to emulate presses in benches.
//  Pulses arriving while busy are queued in a saturating pending counter.
// PARAMETERS
//  HIGH_CYCLES   4     active-level duration per request, >=1 (elaboration assert)
//  LOW_CYCLES    2     mandatory inactive gap after each burst, >=1 (elaboration assert)
//  PEND_W        3     pending counter width; max queued = 2**PEND_W-1
//  OUT_POLARITY  1'b1  active level of level_o
// PORTS
//  clk_i       in   1       single clock, all logic on posedge
//  rst_i       in   1       reset: synchronous, active-high
//  pulse_i     in   1       request; each sampled-high cycle = one request
//  level_o     out  1       stretched output (OUT_POLARITY when active)
//  busy_o      out  1       1 when state != IDLE
//  pending_o   out  PEND_W  queued requests not yet started
//  overflow_o  out  1       one-cycle flag: a request was dropped last cycle
// BEHAVIOUR
//  Reset (rst_i=1 at edge): state IDLE, counters 0, pending_o 0, level_o ~OUT_POLARITY,
//    busy_o 0, overflow_o 0. pulse_i ignored while rst_i=1. Reset mid-burst aborts immediately.
//  FSM (Moore outputs, registered state): IDLE, ACTIVE, GAP.
//   IDLE:   pulse_i=1 -> ACTIVE, cnt<=HIGH_CYCLES-1; request consumed, pending unchanged (0).
//           Invariant: pending_o==0 in IDLE.
//   ACTIVE: level_o=OUT_POLARITY; cnt decrements; cnt==0 -> GAP, cnt<=LOW_CYCLES-1.
//   GAP:    level_o=~OUT_POLARITY; cnt decrements; on last cycle (cnt==0):
//           pending>0        -> ACTIVE, pending <= pending-1+pulse_i (no drop possible)
//           pending==0,pulse -> ACTIVE, pulse consumed directly, pending stays 0
//           otherwise        -> IDLE
//  Latency: pulse_i high at edge N (IDLE) -> level_o active cycles N+1..N+HIGH_CYCLES exactly.
//  Queueing: pulse_i=1 in ACTIVE, or GAP not-last-cycle -> pending+1 if < max,
//    else dropped and overflow_o=1 the following cycle only (one flag per dropped cycle).
//  Burst period = HIGH_CYCLES+LOW_CYCLES; back-to-back bursts have no IDLE cycle.
//  cnt width = $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1); pending arithmetic unsigned, never wraps.
//  busy_o = (state!=IDLE); all outputs glitch-free from flops/state decode only.
// TESTING (defaults HIGH=4, LOW=2, PEND_W=3, OUT_POLARITY=1)
//  1 Single pulse at cyc 10 -> level_o=1 cyc 11-14, 0 from 15; busy_o 11-16; IDLE at 17.
//  2 Pulses at 10,12,13 -> level_o=1 at 11-14, 17-20, 23-26; pending_o 1 after 12, 2 after 13,
//    1 after 16, 0 after 22; overflow_o never set.
//  3 pulse_i held 1 cyc 10-21 -> pending_o saturates at 7 after 18; drops at 19,20,21;
//    overflow_o=1 cyc 20,21,22; exactly 9 bursts total, then IDLE.
//  4 Pulse at 10 plus pulse at 16 (last GAP cyc) -> second burst 17-20, no IDLE cycle, pending 0.
//  5 Pulses at 10,11,12; rst_i=1 at cyc 13 (pulse_i=1 same cyc) -> from 14: level_o=0, busy_o=0,
//    pending_o=0; no further bursts.
//  6 OUT_POLARITY=0, pulse at 10 -> level_o=0 cyc 11-14, 1 elsewhere incl. during reset.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Replays single-cycle request pulses as fixed-length level bursts (active for HIGH_CYCLES,
// then inactive for LOW_CYCLES), queueing requests that arrive while a burst is in flight.
module pulse_stretcher #(
  parameter int unsigned HIGH_CYCLES  = 4,
  parameter int unsigned LOW_CYCLES   = 2,
  parameter int unsigned PEND_W       = 3,
  parameter logic        OUT_POLARITY = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              pulse_i,
  output logic              level_o,
  output logic              busy_o,
  output logic [PEND_W-1:0] pending_o,
  output logic              overflow_o
);

  localparam int unsigned MAX_CYCLES = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0]  HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOW_LOAD  = CNT_W'(LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  if (HIGH_CYCLES < 1) begin : g_high_chk
    $error("pulse_stretcher: HIGH_CYCLES must be >= 1");
  end
  if (LOW_CYCLES < 1) begin : g_low_chk
    $error("pulse_stretcher: LOW_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [PEND_W-1:0] pend_q,  pend_d;
  logic              ovf_q,   ovf_d;
  logic              cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    ovf_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Requests are consumed on the spot; pending stays at zero while idle.
        if (pulse_i) begin
          state_d = ACTIVE;
          cnt_d   = HIGH_LOAD;
        end
      end

      ACTIVE: begin
        if (pulse_i) begin
          if (pend_q != PEND_MAX) pend_d = pend_q + PEND_ONE;
          else                    ovf_d  = 1'b1;
        end
        if (cnt_zero) begin
          state_d = GAP;
          cnt_d   = LOW_LOAD;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      GAP: begin
        if (cnt_zero) begin
          // Last gap cycle: start the next burst with no idle cycle if anything is waiting.
          if (pend_q != '0) begin
            state_d = ACTIVE;
            cnt_d   = HIGH_LOAD;
            if (!pulse_i) pend_d = pend_q - PEND_ONE;
          end else if (pulse_i) begin
            state_d = ACTIVE;
            cnt_d   = HIGH_LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
          if (pulse_i) begin
            if (pend_q != PEND_MAX) pend_d = pend_q + PEND_ONE;
            else                    ovf_d  = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        pend_d  = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode registered state only, so they cannot glitch on pulse_i.
  assign level_o    = (state_q == ACTIVE) ? OUT_POLARITY : ~OUT_POLARITY;
  assign busy_o     = (state_q != IDLE);
  assign pending_o  = pend_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: default-polarity instance plus an inverted-polarity
// instance sharing the same stimulus; expected waveforms are hand-derived cycle ranges.
module tb_pulse_stretcher;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       rst_i;
  logic       pulse_i;
  logic       level,   busy,   ovf;
  logic [2:0] pend;
  logic       level_n, busy_n, ovf_n;
  logic [2:0] pend_n;

  int n_vec = 0;
  int n_err = 0;

  pulse_stretcher #(
    .HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(3), .OUT_POLARITY(1'b1)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .pulse_i(pulse_i),
    .level_o(level), .busy_o(busy), .pending_o(pend), .overflow_o(ovf)
  );

  pulse_stretcher #(
    .HIGH_CYCLES(4), .LOW_CYCLES(2), .PEND_W(3), .OUT_POLARITY(1'b0)
  ) dut_n (
    .clk_i(clk_i), .rst_i(rst_i), .pulse_i(pulse_i),
    .level_o(level_n), .busy_o(busy_n), .pending_o(pend_n), .overflow_o(ovf_n)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string t, input int c, input logic el, input logic eb,
                         input logic [2:0] ep, input logic eo);
    chk($sformatf("%s_level@%0d", t, c), {7'd0, level}, {7'd0, el});
    chk($sformatf("%s_busy@%0d",  t, c), {7'd0, busy},  {7'd0, eb});
    chk($sformatf("%s_pend@%0d",  t, c), {5'd0, pend},  {5'd0, ep});
    chk($sformatf("%s_ovf@%0d",   t, c), {7'd0, ovf},   {7'd0, eo});
  endtask

  // Holds reset for two edges, checks reset outputs of both instances, then releases.
  // The cycle in which reset is released is cycle 0.
  task automatic start(input string t);
    rst_i   = 1'b1;
    pulse_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    chk_all({t, "_rst"}, 0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk({t, "_rst_level_n"}, {7'd0, level_n}, 8'd1);
    chk({t, "_rst_busy_n"},  {7'd0, busy_n},  8'd0);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic el, eb, eo;
    logic [2:0] ep;

    rst_i   = 1'b1;
    pulse_i = 1'b0;

    // 1 + 6: single pulse at 10; inverted instance mirrors level, same busy/pending.
    start("t1");
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk_i);
      el = (c >= 11 && c <= 14);
      eb = (c >= 11 && c <= 16);
      chk_all("t1", c, el, eb, 3'd0, 1'b0);
      chk($sformatf("t6_level_n@%0d", c), {7'd0, level_n}, {7'd0, ~el});
      chk($sformatf("t6_busy_n@%0d",  c), {7'd0, busy_n},  {7'd0, eb});
      chk($sformatf("t6_pend_n@%0d",  c), {5'd0, pend_n},  8'd0);
      chk($sformatf("t6_ovf_n@%0d",   c), {7'd0, ovf_n},   8'd0);
      pulse_i = (c == 10);
    end

    // 2: pulses at 10, 12, 13 -> three back-to-back bursts.
    start("t2");
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20) || (c >= 23 && c <= 26);
      eb = (c >= 11 && c <= 28);
      if (c == 13)                ep = 3'd1;
      else if (c >= 14 && c <= 16) ep = 3'd2;
      else if (c >= 17 && c <= 22) ep = 3'd1;
      else                         ep = 3'd0;
      chk_all("t2", c, el, eb, ep, 1'b0);
      pulse_i = (c == 10 || c == 12 || c == 13);
    end

    // 3: pulse held 10..21 -> saturation at 7, three drops, nine bursts in total.
    start("t3");
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk_i);
      el = (c >= 11 && c <= 62) && (((c - 11) % 6) < 4);
      eb = (c >= 11 && c <= 64);
      if (c >= 12 && c <= 16)      ep = 3'(c - 11);
      else if (c == 17)            ep = 3'd5;
      else if (c == 18)            ep = 3'd6;
      else if (c >= 19 && c <= 22) ep = 3'd7;
      else if (c >= 23 && c <= 64) ep = 3'(6 - (c - 23) / 6);
      else                         ep = 3'd0;
      eo = (c >= 20 && c <= 22);
      chk_all("t3", c, el, eb, ep, eo);
      pulse_i = (c >= 10 && c <= 21);
    end

    // 4: second pulse on the last gap cycle chains straight into another burst.
    start("t4");
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk_i);
      el = (c >= 11 && c <= 14) || (c >= 17 && c <= 20);
      eb = (c >= 11 && c <= 22);
      chk_all("t4", c, el, eb, 3'd0, 1'b0);
      pulse_i = (c == 10 || c == 16);
    end

    // 5: reset mid-burst with a pulse in the same cycle aborts everything.
    start("t5");
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_i);
      el = (c >= 11 && c <= 13);
      eb = (c >= 11 && c <= 13);
      if (c == 12)      ep = 3'd1;
      else if (c == 13) ep = 3'd2;
      else              ep = 3'd0;
      chk_all("t5", c, el, eb, ep, 1'b0);
      chk($sformatf("t5_level_n@%0d", c), {7'd0, level_n}, {7'd0, ~el});
      pulse_i = (c >= 10 && c <= 13);
      rst_i   = (c == 13);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
